// File: rtl/scan_pe_pkg.sv
// Shared arithmetic for the SCAN processing-element array: LLR range limits,
// the saturating adder and the min-sum kernel, plus the update-mode encoding.
package scan_pe_pkg;

  typedef enum logic {
    MODE_F = 1'b0,
    MODE_G = 1'b1
  } mode_e;

  // Largest representable LLR for a w-bit two's-complement value.
  function automatic int llr_ceil(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative representable LLR for a w-bit two's-complement value.
  function automatic int llr_flor(input int w);
    return -(1 << (w - 1));
  endfunction

  // Full-precision sum clamped into the w-bit LLR range.
  function automatic int sat_add(input int x, input int y, input int w);
    int s;
    s = x + y;
    if (s > llr_ceil(w)) begin
      s = llr_ceil(w);
    end else if (s < llr_flor(w)) begin
      s = llr_flor(w);
    end
    return s;
  endfunction

  // Min-sum: sign is the XOR of input signs, magnitude the smaller one.
  // The magnitude of the most negative value does not fit, so it clamps to
  // the ceiling; a zero magnitude always produces +0 regardless of sign.
  function automatic int minsum(input int x, input int y, input int w);
    int  mx;
    int  my;
    int  m;
    logic neg;
    mx  = (x < 0) ? -x : x;
    my  = (y < 0) ? -y : y;
    m   = (mx < my) ? mx : my;
    neg = (x < 0) ^ (y < 0);
    if (m > llr_ceil(w)) begin
      m = llr_ceil(w);
    end
    if (m == 0) begin
      return 0;
    end
    return neg ? -m : m;
  endfunction

endpackage

// File: rtl/scan_pe_lane.sv
// One lane of the SCAN PE array: two registered stages computing either the
// f-type update minsum(a, b + c) or the g-type update minsum(a, b) + c.
// Handshake enables and stage valids come from the array top level.
module scan_pe_lane
  import scan_pe_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en1_i,
  input  logic                    en2_i,
  input  logic                    vld_i,
  input  logic                    vld_p1_i,
  input  logic                    mode_i,
  input  logic                    mode_p1_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] c_i,
  output logic signed [WIDTH-1:0] d_o
);

  logic signed [WIDTH-1:0] t_p1_d;
  logic signed [WIDTH-1:0] t_p1_q;
  logic signed [WIDTH-1:0] a_p1_q;
  logic signed [WIDTH-1:0] c_p1_q;
  logic signed [WIDTH-1:0] d_p2_d;
  logic signed [WIDTH-1:0] d_p2_q;

  // ---- stage 1: f-type pre-adds b + c, g-type pre-combines a and b ----
  // First-stage partial result selected by the vector's mode.
  always_comb begin
    t_p1_d = '0;
    if (mode_i == MODE_F) begin
      t_p1_d = WIDTH'(sat_add(int'(b_i), int'(c_i), WIDTH));
    end else begin
      t_p1_d = WIDTH'(minsum(int'(a_i), int'(b_i), WIDTH));
    end
  end

  // Stage-1 data registers; no reset needed since vld_p1 gates their use.
  always_ff @(posedge clk_i) begin
    if (en1_i && vld_i) begin
      t_p1_q <= t_p1_d;
      a_p1_q <= a_i;
      c_p1_q <= c_i;
    end
  end

  // ---- stage 2: f-type finishes with min-sum, g-type with the add ----
  // Final result selected by the mode registered alongside stage 1.
  always_comb begin
    d_p2_d = '0;
    if (mode_p1_i == MODE_F) begin
      d_p2_d = WIDTH'(minsum(int'(a_p1_q), int'(t_p1_q), WIDTH));
    end else begin
      d_p2_d = WIDTH'(sat_add(int'(t_p1_q), int'(c_p1_q), WIDTH));
    end
  end

  // Output register; cleared on reset so out_d reads zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_p2_q <= '0;
    end else if (en2_i && vld_p1_i) begin
      d_p2_q <= d_p2_d;
    end
  end

  assign d_o = d_p2_q;

endmodule

// File: rtl/scan_pe_array.sv
// SCAN processing-element array: LANES independent lanes sharing one mode
// and tag per vector, two pipeline stages with valid/ready flow control.
// in_ready is a single combinational path from out_ready (no skid buffer),
// so a full pipe keeps streaming at one vector per cycle while out_ready=1.
module scan_pe_array
  import scan_pe_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int LANES = 16,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_d,
  output logic [TAG_W-1:0]       out_tag
);

  logic             en1;
  logic             en2;
  logic             vld_p1_d;
  logic             vld_p1_q;
  logic             vld_p2_d;
  logic             vld_p2_q;
  logic             mode_p1_q;
  logic [TAG_W-1:0] tag_p1_q;
  logic [TAG_W-1:0] tag_p2_q;

  // Stage enables: a stage advances when it is empty or its successor moves.
  always_comb begin
    en2      = !vld_p2_q || out_ready;
    en1      = !vld_p1_q || en2;
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (en1) begin
      vld_p1_d = in_valid;
    end
    if (en2) begin
      vld_p2_d = vld_p1_q;
    end
  end

  // Stage valid flags; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 1: per-vector mode and tag ride with the lane data ----
  // Sideband registers for stage 1, loaded on an accepted vector.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      mode_p1_q <= in_mode;
      tag_p1_q  <= in_tag;
    end
  end

  // ---- stage 2: tag presented with the result ----
  // Output tag register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_p2_q <= '0;
    end else if (en2 && vld_p1_q) begin
      tag_p2_q <= tag_p1_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    scan_pe_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk_i    (clk),
      .rst_i    (rst),
      .en1_i    (en1),
      .en2_i    (en2),
      .vld_i    (in_valid),
      .vld_p1_i (vld_p1_q),
      .mode_i   (in_mode),
      .mode_p1_i(mode_p1_q),
      .a_i      (in_a[i*WIDTH +: WIDTH]),
      .b_i      (in_b[i*WIDTH +: WIDTH]),
      .c_i      (in_c[i*WIDTH +: WIDTH]),
      .d_o      (out_d[i*WIDTH +: WIDTH])
    );
  end

  assign in_ready  = en1;
  assign out_valid = vld_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_scan_pe_array.sv
// Directed and randomized bench for scan_pe_array with WIDTH=10, LANES=16.
module tb_scan_pe_array;

  localparam int W  = 10;
  localparam int L  = 16;
  localparam int TW = 8;
  localparam int VW = L * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic [VW-1:0] in_a;
  logic [VW-1:0] in_b;
  logic [VW-1:0] in_c;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_d;
  logic [TW-1:0] out_tag;

  int n_total = 0;
  int n_bad   = 0;
  bit acc;

  logic [VW-1:0] exp_d_q[$];
  logic [TW-1:0] exp_t_q[$];

  always #5 clk = ~clk;

  scan_pe_array #(.WIDTH(W), .LANES(L), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_d    (out_d),
    .out_tag  (out_tag)
  );

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic for a 10-bit LLR: range [-512, 511].
  function automatic int ref_sat(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int ref_ms(input int x, input int y);
    int ax;
    int ay;
    int m;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    m  = (ay < ax) ? ay : ax;
    if (m > 511) m = 511;
    if (m == 0) return 0;
    if ((x < 0) != (y < 0)) return -m;
    return m;
  endfunction

  function automatic logic [VW-1:0] ref_vec(input logic mode, input logic [VW-1:0] a,
                                            input logic [VW-1:0] b, input logic [VW-1:0] c);
    logic [VW-1:0] r;
    int ai;
    int bi;
    int ci;
    int d;
    r = '0;
    for (int i = 0; i < L; i++) begin
      ai = int'($signed(a[i*W +: W]));
      bi = int'($signed(b[i*W +: W]));
      ci = int'($signed(c[i*W +: W]));
      if (mode) d = ref_sat(ref_ms(ai, bi) + ci);
      else      d = ref_ms(ai, ref_sat(bi + ci));
      r[i*W +: W] = d[W-1:0];
    end
    return r;
  endfunction

  // Lane i holds base + step*i.
  function automatic logic [VW-1:0] lane_vec(input int base, input int step);
    logic [VW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < L; i++) begin
      v = base + step * i;
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One cycle with scoreboard: checks in_ready against occupancy, compares
  // any presented output with the oldest expected entry, records accepts.
  task automatic cyc();
    @(negedge clk);
    acc = in_valid && in_ready;
    check_val("in_ready", VW'(in_ready), VW'((exp_d_q.size() < 2) || out_ready));
    if (out_valid) begin
      if (exp_d_q.size() == 0) begin
        check_val("spurious_out", VW'(out_valid), VW'(0));
      end else begin
        check_val("out_d", out_d, exp_d_q[0]);
        check_val("out_tag", VW'(out_tag), VW'(exp_t_q[0]));
        if (out_ready) begin
          void'(exp_d_q.pop_front());
          void'(exp_t_q.pop_front());
        end
      end
    end
    if (acc) begin
      exp_d_q.push_back(ref_vec(in_mode, in_a, in_b, in_c));
      exp_t_q.push_back(in_tag);
    end
    step_clk();
  endtask

  // Single vector through an empty pipe with hand-computed result.
  task automatic run_one(input string nm, input logic mode, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [VW-1:0] c,
                         input logic [TW-1:0] tag, input logic [VW-1:0] exp);
    in_valid = 1'b1;
    in_mode  = mode;
    in_tag   = tag;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    @(negedge clk);
    check_val({nm, "_accept"}, VW'(in_ready), VW'(1));
    step_clk();
    in_valid = 1'b0;
    @(negedge clk);
    check_val({nm, "_lat1"}, VW'(out_valid), VW'(0));
    step_clk();
    @(negedge clk);
    check_val({nm, "_lat2"}, VW'(out_valid), VW'(1));
    check_val({nm, "_d"}, out_d, exp);
    check_val({nm, "_tag"}, VW'(out_tag), VW'(tag));
    step_clk();
  endtask

  initial begin
    int k;
    int cy;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_tag    = '0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    out_ready = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", VW'(out_valid), VW'(0));
    check_val("rst_in_ready", VW'(in_ready), VW'(1));
    check_val("rst_out_d", out_d, VW'(0));
    check_val("rst_out_tag", VW'(out_tag), VW'(0));
    step_clk();

    // g-type basic: minsum(5,-3) = -3, -3 + 7 = 4
    run_one("g_basic", 1'b1, lane_vec(5, 0), lane_vec(-3, 0), lane_vec(7, 0), 8'h3C, lane_vec(4, 0));
    // f-type: 300+300 saturates to 511, minsum(-100,511) = -100
    run_one("f_sat", 1'b0, lane_vec(-100, 0), lane_vec(300, 0), lane_vec(300, 0), 8'h11, lane_vec(-100, 0));
    // f-type: -7+2 = -5, minsum(0,-5) = +0
    run_one("f_zero", 1'b0, lane_vec(0, 0), lane_vec(-7, 0), lane_vec(2, 0), 8'h12, lane_vec(0, 0));
    // FLOR corner: minsum(-512,-512) = 511, 511+511 saturates to 511
    run_one("g_flor1", 1'b1, lane_vec(-512, 0), lane_vec(-512, 0), lane_vec(511, 0), 8'h21, lane_vec(511, 0));
    // FLOR corner: minsum(-512,3) = -3, -3-512 saturates to -512
    run_one("g_flor2", 1'b1, lane_vec(-512, 0), lane_vec(3, 0), lane_vec(-512, 0), 8'h22, lane_vec(-512, 0));

    // Backpressure: six vectors, out_ready low for four cycles mid-stream.
    k  = 0;
    cy = 0;
    while (!(k == 6 && exp_d_q.size() == 0) && cy < 60) begin
      out_ready = !(cy >= 3 && cy < 7);
      if (k < 6) begin
        in_valid = 1'b1;
        in_mode  = k[0];
        in_tag   = TW'(k);
        in_a     = lane_vec(-8 - 30 * k, 1 + k);
        in_b     = lane_vec(-20 + 50 * k, 3);
        in_c     = lane_vec(7 * k, -1 - k);
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (acc) k++;
      cy++;
    end
    check_val("bp_complete", VW'(k == 6 && exp_d_q.size() == 0), VW'(1));
    out_ready = 1'b1;

    // Reset with both stages full and the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_a      = lane_vec(-8, 1);
    in_b      = lane_vec(-20, 3);
    in_c      = lane_vec(0, -1);
    in_tag    = 8'hA0;
    cyc();
    in_tag = 8'hA1;
    cyc();
    in_tag = 8'hA2;
    cyc();
    check_val("full_before_rst", VW'(exp_d_q.size()), VW'(2));
    rst    = 1'b1;
    in_tag = 8'hEE;
    step_clk();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_d_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    check_val("mid_rst_out_valid", VW'(out_valid), VW'(0));
    check_val("mid_rst_in_ready", VW'(in_ready), VW'(1));
    check_val("mid_rst_out_d", out_d, VW'(0));
    check_val("mid_rst_out_tag", VW'(out_tag), VW'(0));
    step_clk();
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) cyc();

    // Random traffic: lane pattern and random lane values, random handshakes.
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 1'($urandom_range(0, 1));
      in_tag    = TW'($urandom);
      if (n % 2 == 0) begin
        in_a = lane_vec(-8, 1);
        in_b = lane_vec(-20, 3);
        in_c = lane_vec(0, -1);
      end else begin
        for (int i = 0; i < L; i++) begin
          in_a[i*W +: W] = W'($urandom);
          in_b[i*W +: W] = W'($urandom);
          in_c[i*W +: W] = W'($urandom);
        end
      end
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && exp_d_q.size() != 0; n++) cyc();
    check_val("drain_empty", VW'(exp_d_q.size()), VW'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
